// File: rtl/seq_stage_controller_pkg.sv
// Shared definitions for the SEQ stage sequencer: stage encodings, status codes
// and the number of enabled datapath stages.
package seq_stage_controller_pkg;

  typedef enum logic [2:0] {
    STG_IDLE      = 3'd0,
    STG_FETCH     = 3'd1,
    STG_DECODE    = 3'd2,
    STG_EXECUTE   = 3'd3,
    STG_MEMORY    = 3'd4,
    STG_WRITEBACK = 3'd5,
    STG_PC_UPDATE = 3'd6,
    STG_HALT      = 3'd7
  } stage_e;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam int unsigned STAGE_NUM = 6;

endpackage

// File: rtl/seq_stage_decoder.sv
// Combinational stage code to one-hot stage enable; IDLE and HALT enable nothing.
// Shared with the pipelined sequencer.
module seq_stage_decoder
  import seq_stage_controller_pkg::*;
(
  input  logic [2:0]           i_stage_id,
  output logic [STAGE_NUM-1:0] o_stage_en
);

  always_comb begin
    o_stage_en = '0;
    case (i_stage_id)
      STG_FETCH:     o_stage_en[0] = 1'b1;
      STG_DECODE:    o_stage_en[1] = 1'b1;
      STG_EXECUTE:   o_stage_en[2] = 1'b1;
      STG_MEMORY:    o_stage_en[3] = 1'b1;
      STG_WRITEBACK: o_stage_en[4] = 1'b1;
      STG_PC_UPDATE: o_stage_en[5] = 1'b1;
      default:       o_stage_en = '0;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Y86 SEQ sequencer: steps FETCH..PC_UPDATE, stalls on data memory, latches HALT,
// counts retired instructions. Optional macro SEQ_SKIP_MEM_EN bypasses MEMORY.
module seq_stage_controller
  import seq_stage_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mem_need,
  input  logic                 mem_ready,
  input  logic [1:0]           stat,
  output logic [2:0]           stage_id,
  output logic [STAGE_NUM-1:0] stage_en,
  output logic                 busy,
  output logic                 halted,
  output logic                 instr_done,
  output logic [CNT_W-1:0]     instr_count
);

  stage_e                r_state;
  stage_e                w_next;
  logic                  r_done;
  logic [CNT_W-1:0]      r_count;
  logic [STAGE_NUM-1:0]  w_stage_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STG_IDLE;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == STG_PC_UPDATE);
      if (r_state == STG_PC_UPDATE)
        r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      STG_IDLE:      if (start) w_next = STG_FETCH;
      STG_FETCH:     w_next = STG_DECODE;
      STG_DECODE:    w_next = STG_EXECUTE;
`ifdef SEQ_SKIP_MEM_EN
      STG_EXECUTE:   w_next = mem_need ? STG_MEMORY : STG_WRITEBACK;
`else
      STG_EXECUTE:   w_next = STG_MEMORY;
`endif
      STG_MEMORY:    if (!mem_need || mem_ready) w_next = STG_WRITEBACK;
      STG_WRITEBACK: w_next = STG_PC_UPDATE;
      // Error status outranks a stop request so a faulting instruction always halts.
      STG_PC_UPDATE: begin
        if (stat != STAT_AOK) w_next = STG_HALT;
        else if (stop)        w_next = STG_IDLE;
        else                  w_next = STG_FETCH;
      end
      STG_HALT:      w_next = STG_HALT;
      default:       w_next = STG_IDLE;
    endcase
  end

  seq_stage_decoder u_decoder (
    .i_stage_id (r_state),
    .o_stage_en (w_stage_en)
  );

  assign stage_id    = r_state;
  assign stage_en    = w_stage_en;
  assign busy        = (r_state != STG_IDLE) && (r_state != STG_HALT);
  assign halted      = (r_state == STG_HALT);
  assign instr_done  = r_done;
  assign instr_count = r_count;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized bench for seq_stage_controller against an instruction-level stage-list model.
module tb_seq_stage_controller;

  localparam int CNT_W = 4;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, mem_need, mem_ready;
  logic [1:0]       stat;
  logic [2:0]       stage_id;
  logic [5:0]       stage_en;
  logic             busy, halted, instr_done;
  logic [CNT_W-1:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;
  int m_count = 0;
  bit m_pend  = 0;

  seq_stage_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .mem_need    (mem_need),
    .mem_ready   (mem_ready),
    .stat        (stat),
    .stage_id    (stage_id),
    .stage_en    (stage_en),
    .busy        (busy),
    .halted      (halted),
    .instr_done  (instr_done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs expected while parked in IDLE (or HALT when hlt=1).
  task automatic check_parked(input bit hlt);
    check("stage_id",    stage_id, hlt ? 7 : 0);
    check("stage_en",    stage_en, 0);
    check("busy",        busy, 0);
    check("halted",      halted, hlt);
    check("instr_done",  instr_done, m_pend);
    check("instr_count", instr_count, m_count & MASK);
    m_pend = 0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check_parked(0);
      start = 1'b0; stop = 1'($urandom); mem_ready = 1'($urandom); stat = 2'($urandom);
      step();
    end
  endtask

  task automatic launch();
    check_parked(0);
    start = 1'b1; stop = 1'($urandom); mem_ready = 1'($urandom);
    step();
  endtask

  // One instruction described at stage-list level; DUT must already be in FETCH.
  task automatic run_instr(input bit need, input int unsigned waits,
                           input logic [1:0] st, input bit stp);
    int unsigned seq[$];
    int unsigned nmem;
    int unsigned mcnt;
    seq = {1, 2, 3};
`ifdef SEQ_SKIP_MEM_EN
    nmem = need ? waits + 1 : 0;
`else
    nmem = need ? waits + 1 : 1;
`endif
    repeat (nmem) seq.push_back(4);
    seq.push_back(5);
    seq.push_back(6);
    mcnt = 0;
    foreach (seq[i]) begin
      check("stage_id",    stage_id, seq[i]);
      check("stage_en",    stage_en, 32'd1 << (seq[i] - 1));
      check("busy",        busy, 1);
      check("halted",      halted, 0);
      check("instr_done",  instr_done, m_pend);
      check("instr_count", instr_count, m_count & MASK);
      m_pend   = 0;
      mem_need = need;
      start    = 1'($urandom);
      stop     = (seq[i] == 6) ? stp : 1'($urandom);
      stat     = (seq[i] == 6) ? st  : 2'($urandom);
      if (seq[i] == 4) begin
        mem_ready = need ? (mcnt == waits) : 1'($urandom);
        mcnt++;
      end else begin
        mem_ready = 1'($urandom);
      end
      step();
    end
    m_count++;
    m_pend = 1;
  endtask

  initial begin
    bool_setup();
  end

  task automatic bool_setup();
    bit stp;
    int unsigned exp_seq[5];
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mem_need = 1'b0; mem_ready = 1'b0; stat = 2'd0;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    step();
    idle_cycles(5);

    // Single instruction, no memory, stop=1 -> back to IDLE
    launch();
    run_instr(0, 0, 2'd0, 1);
    idle_cycles(2);

    // Memory stall of 3 not-ready cycles
    launch();
    run_instr(1, 3, 2'd0, 1);
    idle_cycles(1);

    // Stop asserted mid-instruction then held to PC_UPDATE
    launch();
    run_instr(0, 0, 2'd0, 1);
    idle_cycles(1);

    // Random back-to-back run, long enough to wrap the 4-bit counter
    launch();
    for (int k = 0; k < 30; k++) begin
      stp = ($urandom_range(0, 3) == 0);
      run_instr(1'($urandom), $urandom_range(0, 4), 2'd0, stp);
      if (stp) begin
        idle_cycles($urandom_range(0, 2));
        launch();
      end
    end
    run_instr(0, 0, 2'd0, 1);
    idle_cycles(1);

    // Reset pulsed during a MEMORY stall
    launch();
    exp_seq = '{1, 2, 3, 4, 4};
    foreach (exp_seq[i]) begin
      check("rst_stall_stage", stage_id, exp_seq[i]);
      m_pend = 0;
      mem_need = 1'b1; mem_ready = 1'b0; start = 1'($urandom); stop = 1'($urandom);
      if (i < 4) step();
    end
    #1 rst_n = 1'b0;
    #1;
    m_count = 0;
    m_pend  = 0;
    check_parked(0);
    #1 rst_n = 1'b1;
    step();
    idle_cycles(2);

    // Halt at the third PC_UPDATE, then sticky against start/stop
    launch();
    run_instr(1'($urandom), $urandom_range(0, 2), 2'd0, 0);
    run_instr(1'($urandom), $urandom_range(0, 2), 2'd0, 0);
    run_instr(1'($urandom), $urandom_range(0, 2), 2'd1, 1'($urandom));
    for (int i = 0; i < 20; i++) begin
      check_parked(1);
      start = 1'(i); stop = 1'($urandom); mem_ready = 1'($urandom); stat = 2'($urandom);
      step();
    end
    check("halt_count", instr_count, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

endmodule
